jtframe_osd_cfg: RTL and testbench

Parametrised OSD configuration block. Takes the raw OSD `status` word from the frontend (MiST/MiSTer), filters it against transient changes with a settle window, and commits a stable configuration word. It decodes the committed word into the standard JTFRAME video, sound and DIP controls, and reports every committed change. Pause changes are aligned to the start of vertical blank. Sits between the frontend and the game core.

---
 rtl/jtframe_osd_pkg.sv | 31 +++
 rtl/jtframe_osd_settle.sv | 65 ++++++
 rtl/jtframe_osd_cfg.sv | 109 ++++++++++
 tb/tb_jtframe_osd_cfg.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_osd_pkg.sv
// Shared bit positions of the OSD status word, filter states and the
// decoded-control bundle used by the OSD configuration block.
package jtframe_osd_pkg;
  localparam int FLIP     = 1;
  localparam int ROT      = 2;
  localparam int SCAN_LSB = 3;
  localparam int FX_MSB   = 7;
  localparam int FX_LSB   = 6;
  localparam int PSG      = 8;
  localparam int FM       = 9;
  localparam int TEST     = 10;
  localparam int WIDE     = 11;
  localparam int CREDITS  = 12;

  typedef enum logic { ST_IDLE, ST_WAIT } settle_st_e;

  typedef struct packed {
    logic [7:0] arx;
    logic [7:0] ary;
    logic [1:0] rotate;
    logic       rot_control;
    logic [2:0] scanlines;
    logic [1:0] fxlevel;
    logic       en_mixing;
    logic       enable_fm;
    logic       enable_psg;
    logic       osd_pause;
    logic       dip_test;
    logic       dip_flip;
  } osd_dec_t;
endpackage

// File: rtl/jtframe_osd_settle.sv
// Settle filter: a new status value must hold for SETTLE consecutive
// samples before it is committed as the configuration word.
module jtframe_osd_settle
  import jtframe_osd_pkg::*;
#(
  parameter int SW     = 64,
  parameter int SETTLE = 1024
)(
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] status,
  output logic [SW-1:0] cfg,
  output logic          cfg_chg,
  output logic [SW-1:0] cfg_diff
);
  localparam int            CW   = $clog2(SETTLE);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE - 1);

  settle_st_e    st_q, st_d;
  logic [SW-1:0] cand_q, cfg_q, diff_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chg_q, commit;

  always_comb begin
    commit = 1'b0;
    st_d   = st_q;
    cnt_d  = cnt_q;
    if (status != cand_q)  cnt_d = '0;
    else if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
    // state tracks whether the next candidate differs from the next cfg
    case (st_q)
      ST_IDLE: if (status != cfg_q) st_d = ST_WAIT;
      ST_WAIT: begin
        commit = (cnt_q == CMAX);
        if (commit)                st_d = (status != cand_q) ? ST_WAIT : ST_IDLE;
        else if (status == cfg_q)  st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      cand_q <= '0;
      cnt_q  <= '0;
      cfg_q  <= '0;
      diff_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cand_q <= status;
      cnt_q  <= cnt_d;
      chg_q  <= commit;
      if (commit) begin
        cfg_q  <= cand_q;
        diff_q <= cfg_q ^ cand_q;
      end
    end
  end

  assign cfg      = cfg_q;
  assign cfg_chg  = chg_q;
  assign cfg_diff = diff_q;
endmodule

// File: rtl/jtframe_osd_cfg.sv
// OSD configuration top: settle filter, registered decode of video/sound/DIP
// controls, and pause requests aligned to the start of vertical blank.
module jtframe_osd_cfg
  import jtframe_osd_pkg::*;
#(
  parameter int SW         = 64,
  parameter int SETTLE     = 1024,
  parameter int ARX        = 4,
  parameter int ARY        = 3,
  parameter int VERTICAL   = 0,
  parameter int MISTER     = 1,
  parameter int AUTO_PAUSE = 0
)(
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] status,
  input  logic [6:0]    core_mod,
  input  logic          game_pause,
  input  logic          osd_shown,
  input  logic          LVBL,
  output logic [SW-1:0] cfg,
  output logic          cfg_chg,
  output logic [SW-1:0] cfg_diff,
  output logic [7:0]    hdmi_arx,
  output logic [7:0]    hdmi_ary,
  output logic [1:0]    rotate,
  output logic          rot_control,
  output logic [2:0]    scanlines,
  output logic [1:0]    dip_fxlevel,
  output logic          en_mixing,
  output logic          enable_fm,
  output logic          enable_psg,
  output logic          osd_pause,
  output logic          dip_test,
  output logic          dip_flip,
  output logic          dip_pause
);
  jtframe_osd_settle #(.SW(SW), .SETTLE(SETTLE)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .status   (status),
    .cfg      (cfg),
    .cfg_chg  (cfg_chg),
    .cfg_diff (cfg_diff)
  );

  // during reset the decode registers load the decode of an all-zero word
  logic [CREDITS:0] src;
  logic             tate, rot_ctl, swap_ar, req, lvbl_q, pause_q, unused_bits;
  osd_dec_t         dec_d, dec_q;

  assign src         = rst ? '0 : cfg[CREDITS:0];
  assign unused_bits = ^{core_mod[6:1], src[0]};

  always_comb begin
    tate    = (VERTICAL != 0) && core_mod[0] && ((MISTER == 0) || !src[ROT]);
    rot_ctl = (MISTER == 0) && (VERTICAL != 0) && src[ROT];
    swap_ar = !tate || !core_mod[0];
    dec_d             = '0;
    dec_d.dip_flip    = ~src[FLIP];
    dec_d.dip_test    = ~src[TEST];
    dec_d.en_mixing   = ~src[SCAN_LSB];
    dec_d.enable_psg  = ~src[PSG];
    dec_d.enable_fm   = ~src[FM];
    dec_d.fxlevel     = 2'b10 ^ src[FX_MSB:FX_LSB];
    dec_d.osd_pause   = src[CREDITS];
    dec_d.scanlines   = (MISTER != 0) ? src[SCAN_LSB +: 3] : {1'b0, src[SCAN_LSB +: 2]};
    dec_d.rot_control = rot_ctl;
    dec_d.rotate      = {src[FLIP], tate & ~rot_ctl};
    if (src[WIDE]) begin
      dec_d.arx = 8'd16;
      dec_d.ary = 8'd9;
    end else if (swap_ar) begin
      dec_d.arx = 8'(ARX);
      dec_d.ary = 8'(ARY);
    end else begin
      dec_d.arx = 8'(ARY);
      dec_d.ary = 8'(ARX);
    end
  end

  // cfg here is the pre-commit value when a commit meets a blanking edge
  assign req = game_pause | cfg[CREDITS] | ((AUTO_PAUSE != 0) & osd_shown);

  always_ff @(posedge clk) begin
    dec_q <= dec_d;
    if (rst) begin
      lvbl_q  <= 1'b0;
      pause_q <= 1'b1;
    end else begin
      lvbl_q <= LVBL;
      if (lvbl_q && !LVBL) pause_q <= ~req;
    end
  end

  assign hdmi_arx    = dec_q.arx;
  assign hdmi_ary    = dec_q.ary;
  assign rotate      = dec_q.rotate;
  assign rot_control = dec_q.rot_control;
  assign scanlines   = dec_q.scanlines;
  assign dip_fxlevel = dec_q.fxlevel;
  assign en_mixing   = dec_q.en_mixing;
  assign enable_fm   = dec_q.enable_fm;
  assign enable_psg  = dec_q.enable_psg;
  assign osd_pause   = dec_q.osd_pause;
  assign dip_test    = dec_q.dip_test;
  assign dip_flip    = dec_q.dip_flip;
  assign dip_pause   = pause_q;
endmodule

// File: tb/tb_jtframe_osd_cfg.sv
// Randomized bench for jtframe_osd_cfg with a sample-window reference model
// and directed literal checks of latency, glitching, rotation and pause.
module tb_jtframe_osd_cfg;
  localparam int SW = 64, SETTLE = 16, ARX = 4, ARY = 3;
  localparam int VERTICAL = 1, MISTER = 1, AUTO_PAUSE = 1;

  logic          clk = 1'b0, rst = 1'b1;
  logic [SW-1:0] status = '0;
  logic [6:0]    core_mod = '0;
  logic          game_pause = 1'b0, osd_shown = 1'b0, LVBL = 1'b1;
  logic [SW-1:0] cfg, cfg_diff;
  logic          cfg_chg, rot_control, en_mixing, enable_fm, enable_psg, osd_pause;
  logic          dip_test, dip_flip, dip_pause;
  logic [7:0]    hdmi_arx, hdmi_ary;
  logic [1:0]    rotate, dip_fxlevel;
  logic [2:0]    scanlines;

  int total = 0, bad = 0, pulses = 0;

  jtframe_osd_cfg #(.SW(SW), .SETTLE(SETTLE), .ARX(ARX), .ARY(ARY), .VERTICAL(VERTICAL),
                    .MISTER(MISTER), .AUTO_PAUSE(AUTO_PAUSE)) dut (
    .clk(clk), .rst(rst), .status(status), .core_mod(core_mod), .game_pause(game_pause),
    .osd_shown(osd_shown), .LVBL(LVBL), .cfg(cfg), .cfg_chg(cfg_chg), .cfg_diff(cfg_diff),
    .hdmi_arx(hdmi_arx), .hdmi_ary(hdmi_ary), .rotate(rotate), .rot_control(rot_control),
    .scanlines(scanlines), .dip_fxlevel(dip_fxlevel), .en_mixing(en_mixing),
    .enable_fm(enable_fm), .enable_psg(enable_psg), .osd_pause(osd_pause),
    .dip_test(dip_test), .dip_flip(dip_flip), .dip_pause(dip_pause)
  );

  always #5 clk = ~clk;

  // 50-line frame, 8 lines of vertical blank
  initial forever begin
    repeat (42) @(negedge clk);
    LVBL = 1'b0;
    repeat (8) @(negedge clk);
    LVBL = 1'b1;
  end

  always @(negedge clk) if (cfg_chg) pulses++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] exp_dec(input logic [63:0] c, input logic cm);
    logic tate, rc, swp;
    logic [7:0] ax, ay;
    logic [2:0] sc;
    tate = (VERTICAL != 0) && cm && ((MISTER == 0) || !c[2]);
    rc   = (MISTER == 0) && (VERTICAL != 0) && c[2];
    swp  = !tate || !cm;
    if (c[11])    begin ax = 8'd16;   ay = 8'd9;    end
    else if (swp) begin ax = 8'(ARX); ay = 8'(ARY); end
    else          begin ax = 8'(ARY); ay = 8'(ARX); end
    sc = (MISTER != 0) ? c[5:3] : {1'b0, c[4:3]};
    return {ax, ay, c[1], tate & !rc, rc, sc, 2'b10 ^ c[7:6],
            !c[3], !c[9], !c[8], c[12], !c[10], !c[1]};
  endfunction

  logic [29:0] dut_dec;
  assign dut_dec = {hdmi_arx, hdmi_ary, rotate, rot_control, scanlines, dip_fxlevel,
                    en_mixing, enable_fm, enable_psg, osd_pause, dip_test, dip_flip};

  // Reference: commit when the last SETTLE post-reset samples agree and differ from cfg
  logic [SW-1:0] hist[$];
  logic [SW-1:0] m_cfg = '0, m_diff = '0;
  logic          m_chg = 1'b0, m_pause = 1'b1, m_lv = 1'b0;
  logic [29:0]   m_dec = '0;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      m_cfg = '0; m_diff = '0; m_chg = 1'b0; m_pause = 1'b1; m_lv = 1'b0;
      m_dec = exp_dec('0, core_mod[0]);
    end else begin
      bit same;
      m_dec = exp_dec(m_cfg, core_mod[0]);
      if (m_lv && !LVBL)
        m_pause = ~(game_pause | m_cfg[12] | ((AUTO_PAUSE != 0) & osd_shown));
      m_lv  = LVBL;
      m_chg = 1'b0;
      same  = (hist.size() == SETTLE);
      for (int i = 1; i < hist.size(); i++) if (hist[i] != hist[0]) same = 1'b0;
      if (same && hist[0] != m_cfg) begin
        m_diff = m_cfg ^ hist[0];
        m_cfg  = hist[0];
        m_chg  = 1'b1;
      end
      hist.push_back(status);
      if (hist.size() > SETTLE) void'(hist.pop_front());
    end
    #2;
    chk("m_cfg",   cfg,       m_cfg);
    chk("m_chg",   cfg_chg,   m_chg);
    chk("m_diff",  cfg_diff,  m_diff);
    chk("m_dec",   dut_dec,   m_dec);
    chk("m_pause", dip_pause, m_pause);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // counts edges from the candidate-load edge until cfg_chg, capped
  task automatic wait_commit(output int n);
    n = 0;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #2;
      n = i;
      if (cfg_chg) break;
      if (i == 40) n = 99;
    end
  endtask

  initial begin
    int n;
    step(3);
    chk("rst_cfg", cfg, 0);
    chk("rst_chg", {63'd0, cfg_chg}, 0);
    chk("rst_pause", {63'd0, dip_pause}, 1);
    chk("rst_test", {63'd0, dip_test}, 1);
    chk("rst_flip", {63'd0, dip_flip}, 1);
    rst = 1'b0;

    status = 64'h3; step(20);
    chk("diff1", cfg_diff, 64'h3);
    chk("cfg1", cfg, 64'h3);
    status = 64'h5; step(20);
    chk("diff2", cfg_diff, 64'h6);
    status = 64'h0; step(20);

    pulses = 0;
    status = 64'h100; step(10);
    status = 64'h0;   step(30);
    chk("glitch", pulses, 0);

    // value loads at edge k; pulse at k+16; decode at k+17
    status = 64'h200;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #2 chk("lat_early", {63'd0, cfg_chg}, 0);
    @(posedge clk); #2;
    chk("lat_chg", {63'd0, cfg_chg}, 1);
    chk("lat_fm_hold", {63'd0, enable_fm}, 1);
    @(posedge clk); #2;
    chk("lat_fm", {63'd0, enable_fm}, 0);
    chk("lat_chg_end", {63'd0, cfg_chg}, 0);
    @(negedge clk);

    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      status = 64'(i + 1) << 16;
      step(8);
    end
    chk("hop", pulses, 0);
    status = 64'hABC_0000;
    wait_commit(n);
    chk("stable16", n, SETTLE);
    @(negedge clk);

    core_mod = 7'd1;
    status = 64'h0; step(20);
    chk("rot0", {62'd0, rotate}, 2'b01);
    chk("ar_tate", {48'd0, hdmi_arx, hdmi_ary}, 16'h0304);
    status = 64'h800; step(20);
    chk("ar_wide", {48'd0, hdmi_arx, hdmi_ary}, 16'h1009);
    status = 64'h4; step(20);
    chk("rot_off", {62'd0, rotate}, 2'b00);
    chk("ar_horz", {48'd0, hdmi_arx, hdmi_ary}, 16'h0403);
    status = 64'h0; step(20);

    @(posedge LVBL); step(10);
    game_pause = 1'b1;
    @(negedge LVBL); #1;
    chk("pause_before", {63'd0, dip_pause}, 1);
    @(posedge clk); #2;
    chk("pause_after", {63'd0, dip_pause}, 0);
    @(negedge clk) game_pause = 1'b0;
    step(60);

    status = 64'h300;
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rw_cfg", cfg, 0);
    chk("rw_diff", cfg_diff, 0);
    chk("rw_pause", {63'd0, dip_pause}, 1);
    wait_commit(n);
    chk("rw_full", n, SETTLE);
    @(negedge clk);

    for (int s = 0; s < 160; s++) begin
      case ($urandom_range(0, 6))
        0: status = 64'h0;
        1: status = 64'h3;
        2: status = 64'h1000;
        3: status = 64'h804;
        4: status = 64'h1006;
        5: status = 64'h6C8;
        default: status = {$urandom, $urandom};
      endcase
      core_mod   = 7'($urandom);
      game_pause = ($urandom_range(0, 3) == 0);
      osd_shown  = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 40) == 0);
      step($urandom_range(1, 30));
      rst = 1'b0;
    end
    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
